// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch-stage next-PC sequencer.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_HALT = 2'd2
  } seq_state_e;

  localparam logic [31:0] INSTR_MEM_ADDR_MAX   = 32'h0000_03FC;
  localparam logic [31:0] TRAP_VEC_DEFAULT     = 32'h0000_0004;
  localparam logic [31:0] PC_INC               = 32'd4;
  localparam int          FLUSH_CNT_W          = 3;
  localparam int          FLUSH_CYCLES_DEFAULT = 2;

  // Instructions are word aligned, so the low two address bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Redirect/PC bundle between decode-execute control and the next-PC sequencer.
interface pc_sequencer_if;
  logic        run_i;
  logic [31:0] pc_cur_i;
  logic        stall_i;
  logic        trap_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic [31:0] pc_next_o;
  logic        pc_we_o;
  logic        flush_o;
  logic        misalign_o;
  logic        halted_o;

  modport master (
    output run_i, pc_cur_i, stall_i, trap_i, branch_taken_i, branch_target_i,
           jump_i, jump_target_i,
    input  pc_next_o, pc_we_o, flush_o, misalign_o, halted_o
  );

  modport slave (
    input  run_i, pc_cur_i, stall_i, trap_i, branch_taken_i, branch_target_i,
           jump_i, jump_target_i,
    output pc_next_o, pc_we_o, flush_o, misalign_o, halted_o
  );
endinterface

// File: rtl/pc_sequencer_flush_timer.sv
// Reloadable down-counter; output stays high while the count is nonzero.
module pc_flush_timer #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         active_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // A reload restarts the window even if a previous one is still counting.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active_o = (cnt_q != '0);

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: run/halt FSM, redirect priority mux, misalign detect and flush timing.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] ADDR_MAX     = INSTR_MEM_ADDR_MAX,
  parameter logic [31:0] TRAP_VEC     = TRAP_VEC_DEFAULT,
  parameter int          FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input logic           sys_clk,
  input logic           sys_rst,
  pc_sequencer_if.slave bus
);

  seq_state_e  state_q, state_d;
  logic        misalign_q, misalign_d;
  logic        redirect;
  logic [31:0] pc_next;
  logic        pc_we;

  // Priority: trap > branch > jump > halt-at-end > stall > sequential.
  always_comb begin
    state_d    = state_q;
    pc_next    = bus.pc_cur_i;
    pc_we      = 1'b0;
    redirect   = 1'b0;
    misalign_d = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        if (bus.run_i) state_d = SEQ_RUN;
      end
      SEQ_RUN: begin
        if (bus.trap_i) begin
          pc_next  = align_word(TRAP_VEC);
          pc_we    = 1'b1;
          redirect = 1'b1;
        end else if (bus.branch_taken_i) begin
          pc_next    = align_word(bus.branch_target_i);
          pc_we      = 1'b1;
          redirect   = 1'b1;
          misalign_d = |bus.branch_target_i[1:0];
        end else if (bus.jump_i) begin
          pc_next    = align_word(bus.jump_target_i);
          pc_we      = 1'b1;
          redirect   = 1'b1;
          misalign_d = |bus.jump_target_i[1:0];
        end else if (bus.pc_cur_i == ADDR_MAX) begin
          state_d = SEQ_HALT;
        end else if (!bus.stall_i) begin
          pc_next = bus.pc_cur_i + PC_INC;
          pc_we   = 1'b1;
        end
      end
      SEQ_HALT: begin
        state_d = SEQ_HALT;
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= SEQ_IDLE;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= misalign_d;
    end
  end

  // The flush window keeps counting in HALT so a pending flush still completes.
  pc_flush_timer #(
    .W(FLUSH_CNT_W)
  ) u_flush_timer (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .load_i     (redirect),
    .load_val_i (FLUSH_CNT_W'(FLUSH_CYCLES)),
    .active_o   (bus.flush_o)
  );

  assign bus.pc_next_o  = pc_next;
  assign bus.pc_we_o    = pc_we;
  assign bus.misalign_o = misalign_q;
  assign bus.halted_o   = (state_q == SEQ_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector table plus hand-written multi-cycle sequences for pc_sequencer.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic sysClk = 1'b0;
  logic sysRst = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  pc_sequencer_if busIf ();

  pc_sequencer dut (
    .sys_clk (sysClk),
    .sys_rst (sysRst),
    .bus     (busIf)
  );

  always #5 sysClk = ~sysClk;

  typedef struct {
    logic        trap;
    logic        br;
    logic [31:0] brTgt;
    logic        jmp;
    logic [31:0] jmpTgt;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] expNext;
    logic        expWe;
    logic        expMis;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic run, input logic trap, input logic br,
                               input logic [31:0] brTgt, input logic jmp,
                               input logic [31:0] jmpTgt, input logic stall,
                               input logic [31:0] pc);
    busIf.run_i           = run;
    busIf.trap_i          = trap;
    busIf.branch_taken_i  = br;
    busIf.branch_target_i = brTgt;
    busIf.jump_i          = jmp;
    busIf.jump_target_i   = jmpTgt;
    busIf.stall_i         = stall;
    busIf.pc_cur_i        = pc;
    #2;
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic idleRun(input logic [31:0] pc);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, pc);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h40,        32'h44,  1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h100,      1'b1, 32'h200, 1'b1, 32'h40,        32'h100, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h100,      1'b0, 32'h0,   1'b0, 32'h104,       32'h4,   1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h123, 1'b0, 32'h8,         32'h120, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 32'h80,        32'h80,  1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 32'h202,      1'b0, 32'h0,   1'b1, 32'h80,        32'h200, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'hFFFF_FFFC, 32'h0,   1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h300, 1'b1, 32'h10,        32'h300, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h3,   1'b0, 32'h20,        32'h4,   1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 32'h101,      1'b1, 32'h200, 1'b0, 32'h30,        32'h100, 1'b1, 1'b1};

    idleRun(32'h0);
    tick();
    tick();
    checkOutput("reset_flush", 32'(busIf.flush_o), 32'h0);
    checkOutput("reset_misalign", 32'(busIf.misalign_o), 32'h0);
    checkOutput("reset_halted", 32'(busIf.halted_o), 32'h0);
    sysRst = 1'b0;

    // Startup: idle cycles 0..2, run_i at cycle 3, first sequential fetch at cycle 4.
    for (int c = 0; c < 4; c++) begin
      applyStimulus((c == 3), 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput($sformatf("idle_we_c%0d", c), 32'(busIf.pc_we_o), 32'h0);
      tick();
    end
    idleRun(32'h0);
    checkOutput("start_next", busIf.pc_next_o, 32'h4);
    checkOutput("start_we", 32'(busIf.pc_we_o), 32'h1);
    tick();

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, vecs[i].trap, vecs[i].br, vecs[i].brTgt, vecs[i].jmp,
                    vecs[i].jmpTgt, vecs[i].stall, vecs[i].pc);
      checkOutput($sformatf("vec%0d_next", i), busIf.pc_next_o, vecs[i].expNext);
      checkOutput($sformatf("vec%0d_we", i), 32'(busIf.pc_we_o), 32'(vecs[i].expWe));
      tick();
      checkOutput($sformatf("vec%0d_mis", i), 32'(busIf.misalign_o), 32'(vecs[i].expMis));
    end

    // Drain any flush window left by the table.
    for (int i = 0; i < 3; i++) begin
      idleRun(32'h50);
      tick();
    end
    checkOutput("drained_flush", 32'(busIf.flush_o), 32'h0);

    // Single redirect: flush exactly two cycles.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h40);
    tick();
    idleRun(32'h100);
    checkOutput("flush2_c1", 32'(busIf.flush_o), 32'h1);
    tick();
    idleRun(32'h104);
    checkOutput("flush2_c2", 32'(busIf.flush_o), 32'h1);
    tick();
    checkOutput("flush2_c3", 32'(busIf.flush_o), 32'h0);

    // Trap then branch one cycle into the flush: three contiguous flush cycles.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h180, 1'b0, 32'h0, 1'b0, 32'h108);
    checkOutput("trap_next", busIf.pc_next_o, 32'h4);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h180, 1'b0, 32'h0, 1'b0, 32'h4);
    checkOutput("reload_c1", 32'(busIf.flush_o), 32'h1);
    tick();
    idleRun(32'h180);
    checkOutput("reload_c2", 32'(busIf.flush_o), 32'h1);
    tick();
    idleRun(32'h184);
    checkOutput("reload_c3", 32'(busIf.flush_o), 32'h1);
    tick();
    checkOutput("reload_c4", 32'(busIf.flush_o), 32'h0);

    // Redirect at the last address beats halt; then stall plus last address halts.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, INSTR_MEM_ADDR_MAX);
    checkOutput("endbr_next", busIf.pc_next_o, 32'h200);
    checkOutput("endbr_we", 32'(busIf.pc_we_o), 32'h1);
    tick();
    checkOutput("endbr_halted", 32'(busIf.halted_o), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, INSTR_MEM_ADDR_MAX);
    checkOutput("halt_we", 32'(busIf.pc_we_o), 32'h0);
    checkOutput("halt_next", busIf.pc_next_o, INSTR_MEM_ADDR_MAX);
    tick();
    checkOutput("halt_state", 32'(busIf.halted_o), 32'h1);
    checkOutput("halt_flush_pending", 32'(busIf.flush_o), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h3F0);
    checkOutput("halt_ign_we", 32'(busIf.pc_we_o), 32'h0);
    checkOutput("halt_ign_next", busIf.pc_next_o, 32'h3F0);
    tick();
    checkOutput("halt_sticky", 32'(busIf.halted_o), 32'h1);
    checkOutput("halt_flush_done", 32'(busIf.flush_o), 32'h0);

    // Reset while halted.
    sysRst = 1'b1;
    tick();
    sysRst = 1'b0;
    idleRun(32'h0);
    checkOutput("rst_halt_halted", 32'(busIf.halted_o), 32'h0);
    checkOutput("rst_halt_we", 32'(busIf.pc_we_o), 32'h0);

    // Reset during a flush after a misaligned redirect.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2F2, 1'b0, 32'h4);
    tick();
    checkOutput("preflush", 32'(busIf.flush_o), 32'h1);
    sysRst = 1'b1;
    tick();
    sysRst = 1'b0;
    idleRun(32'h2F0);
    checkOutput("rst_flush_flush", 32'(busIf.flush_o), 32'h0);
    checkOutput("rst_flush_mis", 32'(busIf.misalign_o), 32'h0);
    checkOutput("rst_flush_we", 32'(busIf.pc_we_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
